// File: rtl/spi_register_controller.sv
// Register-access sequencer in front of spi_master.
// Sends {rw,addr} then data bytes, one beat outstanding at a time.
module spi_register_controller #(
    parameter int unsigned DATA_BYTES = 1,
    parameter bit          READ_FLAG  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [6:0]              cmd_addr,
    input  logic [8*DATA_BYTES-1:0] cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    mosi_tvalid,
    input  logic                    mosi_tready,
    output logic [7:0]              mosi_tdata,
    input  logic                    miso_tvalid,
    output logic                    miso_tready,
    input  logic [7:0]              miso_tdata,
    output logic                    busy
);

    localparam int unsigned W  = 8 * DATA_BYTES;
    localparam int unsigned IW = $clog2(DATA_BYTES + 1);
    localparam logic [IW-1:0] LAST = IW'(DATA_BYTES);

    generate
        if (DATA_BYTES < 1) begin : g_bad_width
            $error("DATA_BYTES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RX,
        RESPOND
    } state_t;

    state_t         state;
    logic [IW-1:0]  byte_idx;
    logic           wr_q;
    logic [W-1:0]   wdata_q;
    logic [W-1:0]   rdata_q;
    logic [W-1:0]   rdata_next;
    logic [W-1:0]   wshift;
    logic [7:0]     next_tx;

    // Merge the incoming beat into its slot and pick the next data byte.
    always_comb begin
        rdata_next = rdata_q
                   | (W'(miso_tdata) << (8 * (DATA_BYTES - int'(byte_idx))));
        wshift     = wdata_q << (8 * int'(byte_idx));
        next_tx    = wr_q ? wshift[W-1 -: 8] : 8'h00;
    end

    // Access sequencer: command byte, data beats, then response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            byte_idx    <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            mosi_tvalid <= 1'b0;
            mosi_tdata  <= 8'h00;
            miso_tready <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wr_q        <= cmd_write;
                        wdata_q     <= cmd_wdata;
                        rdata_q     <= '0;
                        byte_idx    <= '0;
                        cmd_ready   <= 1'b0;
                        mosi_tvalid <= 1'b1;
                        mosi_tdata  <= {cmd_write ? ~READ_FLAG : READ_FLAG,
                                        cmd_addr};
                        busy        <= 1'b1;
                        state       <= SEND;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SEND: begin
                    if (mosi_tready) begin
                        mosi_tvalid <= 1'b0;
                        miso_tready <= 1'b1;
                        state       <= WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    if (miso_tvalid) begin
                        miso_tready <= 1'b0;
                        if (byte_idx != '0) begin
                            rdata_q <= rdata_next;
                        end
                        if (byte_idx == LAST) begin
                            rsp_valid <= 1'b1;
                            rsp_write <= wr_q;
                            rsp_rdata <= wr_q ? '0 : rdata_next;
                            state     <= RESPOND;
                        end else begin
                            byte_idx    <= byte_idx + 1'b1;
                            mosi_tvalid <= 1'b1;
                            mosi_tdata  <= next_tx;
                            state       <= SEND;
                        end
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_register_controller.sv
// Directed bench for spi_register_controller.
// u1: DATA_BYTES=1, u2: DATA_BYTES=2 (main instance).
module tb_spi_register_controller;

    logic clk;
    logic reset_n;
    int   checks;
    int   passed;

    logic        a_cmd_valid, a_cmd_ready, a_cmd_write;
    logic [6:0]  a_cmd_addr;
    logic [7:0]  a_cmd_wdata;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_write;
    logic [7:0]  a_rsp_rdata;
    logic        a_mosi_tvalid, a_mosi_tready;
    logic [7:0]  a_mosi_tdata;
    logic        a_miso_tvalid, a_miso_tready;
    logic [7:0]  a_miso_tdata;
    logic        a_busy;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [15:0] rsp_rdata;
    logic        mosi_tvalid, mosi_tready;
    logic [7:0]  mosi_tdata;
    logic        miso_tvalid, miso_tready;
    logic [7:0]  miso_tdata;
    logic        busy;

    spi_register_controller #(.DATA_BYTES(1), .READ_FLAG(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_write(a_cmd_write), .cmd_addr(a_cmd_addr),
        .cmd_wdata(a_cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_write(a_rsp_write), .rsp_rdata(a_rsp_rdata),
        .mosi_tvalid(a_mosi_tvalid), .mosi_tready(a_mosi_tready),
        .mosi_tdata(a_mosi_tdata),
        .miso_tvalid(a_miso_tvalid), .miso_tready(a_miso_tready),
        .miso_tdata(a_miso_tdata),
        .busy(a_busy)
    );

    spi_register_controller #(.DATA_BYTES(2), .READ_FLAG(1'b1)) u2 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .mosi_tvalid(mosi_tvalid), .mosi_tready(mosi_tready),
        .mosi_tdata(mosi_tdata),
        .miso_tvalid(miso_tvalid), .miso_tready(miso_tready),
        .miso_tdata(miso_tdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one access on u2 with a 1-cycle SPI model; stops at rsp_valid.
    task automatic run_access(input logic wr, input logic [6:0] addr,
                              input logic [15:0] wd,
                              input logic [7:0] m1, input logic [7:0] m2,
                              output logic [23:0] beats, output logic ok);
        int n;
        ok = 1'b1;
        beats = '0;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (!cmd_ready) ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr = addr;
        cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
        mosi_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!mosi_tvalid && n < 50) begin tick(); n++; end
            if (!mosi_tvalid) ok = 1'b0;
            beats = {beats[15:0], mosi_tdata};
            tick();
            miso_tvalid = 1'b1;
            miso_tdata = (i == 0) ? 8'hEE : (i == 1) ? m1 : m2;
            n = 0;
            while (!miso_tready && n < 50) begin tick(); n++; end
            if (!miso_tready) ok = 1'b0;
            tick();
            miso_tvalid = 1'b0;
        end
        mosi_tready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        if (!rsp_valid) ok = 1'b0;
    endtask

    // Finishes an access already accepted by u2 and consumes its response.
    task automatic drain(output logic ok);
        int n;
        mosi_tready = 1'b1;
        miso_tvalid = 1'b1;
        miso_tdata = 8'h00;
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        ok = rsp_valid;
        mosi_tready = 1'b0;
        miso_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_write, rsp_rdata, mosi_tvalid,
             mosi_tdata, miso_tready, busy} !== 29'd0)
            $display("FAIL rst_u2_outputs: got nonzero outputs");
        else passed++;
        checks++;
        if ({a_cmd_ready, a_rsp_valid, a_rsp_write, a_rsp_rdata,
             a_mosi_tvalid, a_mosi_tdata, a_miso_tready, a_busy} !== 21'd0)
            $display("FAIL rst_u1_outputs: got nonzero outputs");
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++;
        if ({cmd_ready, a_cmd_ready} !== 2'b00)
            $display("FAIL rst_ready_early: got %b want 00",
                     {cmd_ready, a_cmd_ready});
        else passed++;
        tick();
        checks++;
        if ({cmd_ready, a_cmd_ready, busy, a_busy} !== 4'b1100)
            $display("FAIL rst_ready_rise: got %b want 1100",
                     {cmd_ready, a_cmd_ready, busy, a_busy});
        else passed++;
    endtask

    task automatic test_write_1byte();
        a_mosi_tready = 1'b1;
        a_miso_tvalid = 1'b1;
        a_miso_tdata = 8'h00;
        a_cmd_valid = 1'b1;
        a_cmd_write = 1'b1;
        a_cmd_addr = 7'h12;
        a_cmd_wdata = 8'hA5;
        tick();
        a_cmd_valid = 1'b0;
        checks++;
        if ({a_mosi_tvalid, a_mosi_tdata, a_cmd_ready} !== {1'b1, 8'h12, 1'b0})
            $display("FAIL w1_cmd_byte: got %b_%h want 1_12",
                     a_mosi_tvalid, a_mosi_tdata);
        else passed++;
        tick();
        tick();
        checks++;
        if ({a_mosi_tvalid, a_mosi_tdata} !== {1'b1, 8'hA5})
            $display("FAIL w1_data_byte: got %b_%h want 1_a5",
                     a_mosi_tvalid, a_mosi_tdata);
        else passed++;
        tick();
        tick();
        checks++;
        if ({a_rsp_valid, a_rsp_write, a_rsp_rdata, a_mosi_tvalid}
            !== {1'b1, 1'b1, 8'h00, 1'b0})
            $display("FAIL w1_rsp: got v%b w%b d%h want v1 w1 d00",
                     a_rsp_valid, a_rsp_write, a_rsp_rdata);
        else passed++;
        a_miso_tvalid = 1'b0;
        a_mosi_tready = 1'b0;
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
        checks++;
        if ({a_rsp_valid, a_cmd_ready, a_busy} !== 3'b010)
            $display("FAIL w1_done: got %b want 010",
                     {a_rsp_valid, a_cmd_ready, a_busy});
        else passed++;
    endtask

    task automatic test_read_2byte();
        mosi_tready = 1'b1;
        miso_tvalid = 1'b1;
        miso_tdata = 8'hFF;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 7'h05;
        cmd_wdata = 16'hDEAD;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({mosi_tvalid, mosi_tdata, cmd_ready, busy, miso_tready}
            !== {1'b1, 8'h85, 1'b0, 1'b1, 1'b0})
            $display("FAIL rd_cmd_byte: got %b_%h want 1_85",
                     mosi_tvalid, mosi_tdata);
        else passed++;
        tick();
        checks++;
        if ({mosi_tvalid, miso_tready} !== 2'b01)
            $display("FAIL rd_wait_rx: got %b want 01",
                     {mosi_tvalid, miso_tready});
        else passed++;
        tick();
        checks++;
        if ({mosi_tvalid, mosi_tdata, miso_tready} !== {1'b1, 8'h00, 1'b0})
            $display("FAIL rd_byte1: got %b_%h want 1_00",
                     mosi_tvalid, mosi_tdata);
        else passed++;
        miso_tdata = 8'h3C;
        tick();
        tick();
        miso_tdata = 8'h7E;
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_write, rsp_rdata, cmd_ready}
            !== {1'b1, 1'b0, 16'h3C7E, 1'b0})
            $display("FAIL rd_rsp: got v%b w%b d%h want v1 w0 d3c7e",
                     rsp_valid, rsp_write, rsp_rdata);
        else passed++;
        miso_tvalid = 1'b0;
        mosi_tready = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010)
            $display("FAIL rd_done: got %b want 010",
                     {rsp_valid, cmd_ready, busy});
        else passed++;
    endtask

    task automatic test_mosi_stall();
        mosi_tready = 1'b1;
        miso_tvalid = 1'b1;
        miso_tdata = 8'h77;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = 7'h21;
        cmd_wdata = 16'hA55A;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({mosi_tvalid, mosi_tdata} !== {1'b1, 8'h21})
            $display("FAIL st_cmd_byte: got %b_%h want 1_21",
                     mosi_tvalid, mosi_tdata);
        else passed++;
        tick();
        mosi_tready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({mosi_tvalid, mosi_tdata, miso_tready} !== {1'b1, 8'hA5, 1'b0})
                $display("FAIL st_hold%0d: got %b_%h_%b want 1_a5_0",
                         i, mosi_tvalid, mosi_tdata, miso_tready);
            else passed++;
            tick();
        end
        mosi_tready = 1'b1;
        tick();
        tick();
        checks++;
        if ({mosi_tvalid, mosi_tdata} !== {1'b1, 8'h5A})
            $display("FAIL st_byte2: got %b_%h want 1_5a",
                     mosi_tvalid, mosi_tdata);
        else passed++;
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_write, rsp_rdata} !== {1'b1, 1'b1, 16'h0000})
            $display("FAIL st_rsp: got v%b w%b d%h want v1 w1 d0000",
                     rsp_valid, rsp_write, rsp_rdata);
        else passed++;
        miso_tvalid = 1'b0;
        mosi_tready = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_rsp_backpressure();
        logic [23:0] beats;
        logic ok;
        run_access(1'b0, 7'h33, 16'h0, 8'h11, 8'h22, beats, ok);
        checks++;
        if ({ok, beats} !== {1'b1, 24'hB30000})
            $display("FAIL bp_beats: got ok%b %h want ok1 b30000", ok, beats);
        else passed++;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = 7'h44;
        cmd_wdata = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid, rsp_rdata, cmd_ready, mosi_tvalid}
                !== {1'b1, 16'h1122, 1'b0, 1'b0})
                $display("FAIL bp_hold%0d: got v%b d%h cr%b want v1 d1122 cr0",
                         i, rsp_valid, rsp_rdata, cmd_ready);
            else passed++;
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, busy, mosi_tvalid} !== 4'b0100)
            $display("FAIL bp_release: got %b want 0100",
                     {rsp_valid, cmd_ready, busy, mosi_tvalid});
        else passed++;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({mosi_tvalid, mosi_tdata, cmd_ready} !== {1'b1, 8'h44, 1'b0})
            $display("FAIL bp_accept: got %b_%h want 1_44",
                     mosi_tvalid, mosi_tdata);
        else passed++;
        drain(ok);
        checks++;
        if ({ok, rsp_write, rsp_rdata} !== {1'b1, 1'b1, 16'h0000})
            $display("FAIL bp_second: got ok%b w%b d%h want ok1 w1 d0000",
                     ok, rsp_write, rsp_rdata);
        else passed++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [23:0] beats;
        logic ok;
        mosi_tready = 1'b1;
        miso_tvalid = 1'b1;
        miso_tdata = 8'hAB;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 7'h0F;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_write, rsp_rdata, mosi_tvalid,
             mosi_tdata, miso_tready, busy} !== 29'd0)
            $display("FAIL mr_outputs: got tv%b td%h busy%b want all 0",
                     mosi_tvalid, mosi_tdata, busy);
        else passed++;
        mosi_tready = 1'b0;
        miso_tvalid = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if (cmd_ready !== 1'b0)
            $display("FAIL mr_ready_early: got %b want 0", cmd_ready);
        else passed++;
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, busy} !== 3'b100)
            $display("FAIL mr_ready_rise: got %b want 100",
                     {cmd_ready, rsp_valid, busy});
        else passed++;
        run_access(1'b0, 7'h0F, 16'h0, 8'h5A, 8'hC3, beats, ok);
        checks++;
        if ({ok, beats, rsp_write, rsp_rdata}
            !== {1'b1, 24'h8F0000, 1'b0, 16'h5AC3})
            $display("FAIL mr_next: got ok%b b%h w%b d%h want ok1 8f0000 w0 5ac3",
                     ok, beats, rsp_write, rsp_rdata);
        else passed++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [23:0] beats;
        logic ok;
        logic [7:0] hi [3];
        logic [7:0] lo [3];
        logic [6:0] ad;
        hi = '{8'h01, 8'hC8, 8'h7F};
        lo = '{8'h80, 8'h3D, 8'hE6};
        for (int k = 0; k < 3; k++) begin
            ad = 7'(k + 1);
            run_access(1'b0, ad, 16'hFFFF, hi[k], lo[k], beats, ok);
            checks++;
            if ({ok, beats, rsp_write, rsp_rdata, busy, cmd_ready}
                !== {1'b1, 1'b1, ad, 16'h0, 1'b0, hi[k], lo[k], 1'b1, 1'b0})
                $display("FAIL b2b_rsp%0d: got ok%b b%h d%h busy%b want d%h%h",
                         k, ok, beats, rsp_rdata, busy, hi[k], lo[k]);
            else passed++;
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            checks++;
            if ({busy, cmd_ready, rsp_valid} !== 3'b010)
                $display("FAIL b2b_idle%0d: got %b want 010",
                         k, {busy, cmd_ready, rsp_valid});
            else passed++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0;
        passed = 0;
        reset_n = 1'b0;
        a_cmd_valid = 1'b0; a_cmd_write = 1'b0;
        a_cmd_addr = '0; a_cmd_wdata = '0;
        a_rsp_ready = 1'b0; a_mosi_tready = 1'b0;
        a_miso_tvalid = 1'b0; a_miso_tdata = '0;
        cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; mosi_tready = 1'b0;
        miso_tvalid = 1'b0; miso_tdata = '0;
        test_reset();
        test_write_1byte();
        test_read_2byte();
        test_mosi_stall();
        test_rsp_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
